display_digits_de0: RTL

Parametrised static seven-segment driver for DE0-class boards, driving N_DIGITS independent HEX displays that each have dedicated pins. It replaces per-digit combinational decoding in board top levels with a registered digit store. The store is written by a parallel load or a nibble shift-in. Output features are leading-zero blanking, per-digit decimal points, per-digit blinking and a blank/valid state per digit. It sits between CPU or debug registers and the board HEX pins.

---
 rtl/display_de0_pkg.sv | 45 ++++
 rtl/seg7_font_de0.sv | 13 +
 rtl/display_digits_de0.sv | 126 ++++++++++++
 3 files changed

// File: rtl/display_de0_pkg.sv
// Shared constants and the canonical seven-segment font for the DE0 digit driver.
// Segment encodings are active-high: bit 0 = a ... bit 6 = g.
package display_de0_pkg;

  localparam int unsigned SEG_W    = 7;
  localparam int unsigned NIB_W    = 4;
  localparam int unsigned DIGIT_W  = 8;

  localparam int unsigned SEG_A    = 0;
  localparam int unsigned SEG_B    = 1;
  localparam int unsigned SEG_C    = 2;
  localparam int unsigned SEG_D    = 3;
  localparam int unsigned SEG_E    = 4;
  localparam int unsigned SEG_F    = 5;
  localparam int unsigned SEG_G    = 6;
  localparam int unsigned DP_BIT   = 7;

  // One display with every segment and the dp dark, active-high form.
  localparam logic [DIGIT_W-1:0] SEG_OFF = 8'h00;

  function automatic logic [SEG_W-1:0] seg7_font(input logic [NIB_W-1:0] nib);
    logic [SEG_W-1:0] s;
    s = 7'h00;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_font_de0.sv
// Combinational hexadecimal nibble to active-high segment decoder.
module seg7_font_de0
  import display_de0_pkg::*;
(
  input  logic [NIB_W-1:0] nibble_i,
  output logic [SEG_W-1:0] seg_c_o
);

  always_comb begin
    seg_c_o = seg7_font(nibble_i);
  end

endmodule

// File: rtl/display_digits_de0.sv
// Registered static seven-segment driver: digit store with load/shift-in,
// leading-zero blanking, per-digit dp and blink, and a registered hex output.
module display_digits_de0
  import display_de0_pkg::*;
#(
  parameter int unsigned N_DIGITS   = 4,
  parameter int unsigned BLINK_DIV  = 25_000_000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [NIB_W*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]       dp,
  input  logic                      push,
  input  logic [NIB_W-1:0]          push_nibble,
  input  logic                      clear,
  input  logic                      lz_blank,
  input  logic [N_DIGITS-1:0]       blink_mask,
  output logic [DIGIT_W*N_DIGITS-1:0] hex
);

  localparam int unsigned DW    = NIB_W * N_DIGITS;
  localparam int unsigned HW    = DIGIT_W * N_DIGITS;
  localparam int unsigned CNT_W = $clog2(BLINK_DIV + 1);
  localparam logic [HW-1:0] HEX_OFF = ACTIVE_LOW ? {HW{1'b1}} : {HW{1'b0}};

  logic [DW-1:0]       digit_q, digit_d;
  logic [N_DIGITS-1:0] dp_q, dp_d;
  logic [N_DIGITS-1:0] valid_q, valid_d;
  logic                lz_q;
  logic [N_DIGITS-1:0] mask_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic [HW-1:0]       hex_q, hex_d;

  logic [N_DIGITS-1:0][SEG_W-1:0] seg_c;
  logic [N_DIGITS-1:0]            lz_hidden_c;
  logic                           zero_run_c;
  logic                           shown_c;
  logic [DIGIT_W-1:0]             digit_byte_c;

  // Digit store update, clear > load > push.
  always_comb begin
    digit_d = digit_q;
    dp_d    = dp_q;
    valid_d = valid_q;
    if (clear) begin
      digit_d = '0;
      dp_d    = '0;
      valid_d = '0;
    end else if (load) begin
      digit_d = value;
      dp_d    = dp;
      valid_d = '1;
    end else if (push) begin
      digit_d = (digit_q << NIB_W) | DW'(push_nibble);
      dp_d    = dp_q << 1;
      valid_d = (valid_q << 1) | N_DIGITS'(1);
    end
  end

  // Free-running blink divider; phase flips on each wrap.
  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    phase_d = phase_q;
    if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_font
    seg7_font_de0 u_font (
      .nibble_i (digit_q[g*NIB_W +: NIB_W]),
      .seg_c_o  (seg_c[g])
    );
  end

  // Zero run scanned from the MSD down; invalid digits count as zero.
  always_comb begin
    lz_hidden_c = '0;
    zero_run_c  = 1'b1;
    for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
      zero_run_c = zero_run_c &
                   ((digit_q[i*NIB_W +: NIB_W] == 4'h0) | ~valid_q[i]);
      lz_hidden_c[i] = lz_q & zero_run_c & (i != 0);
    end
  end

  always_comb begin
    hex_d        = '0;
    shown_c      = 1'b0;
    digit_byte_c = SEG_OFF;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      shown_c      = valid_q[i] & ~lz_hidden_c[i] & ~(phase_q & mask_q[i]);
      digit_byte_c = shown_c ? {dp_q[i], seg_c[i]} : SEG_OFF;
      hex_d[i*DIGIT_W +: DIGIT_W] = ACTIVE_LOW ? ~digit_byte_c : digit_byte_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= '0;
      dp_q    <= '0;
      valid_q <= '0;
      lz_q    <= 1'b0;
      mask_q  <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      hex_q   <= HEX_OFF;
    end else begin
      digit_q <= digit_d;
      dp_q    <= dp_d;
      valid_q <= valid_d;
      lz_q    <= lz_blank;
      mask_q  <= blink_mask;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      hex_q   <= hex_d;
    end
  end

  assign hex = hex_q;

endmodule
